// File: rtl/change_dispenser.sv
// Change-return engine: greedily ejects the largest eligible coin one handshake at a time,
// tracks per-denomination inventory and reports completion or a short-pay remainder.
module change_dispenser #(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 4,
    parameter int DEN_HI   = 10,
    parameter int DEN_MID  = 5,
    parameter int DEN_LO   = 1,
    parameter int INIT_INV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] amount,
    input  logic             load,
    input  logic [CNT_W-1:0] load_hi,
    input  logic [CNT_W-1:0] load_mid,
    input  logic [CNT_W-1:0] load_lo,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    input  logic             coin_ready,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [WIDTH-1:0] remaining,
    output logic [CNT_W-1:0] inv_hi,
    output logic [CNT_W-1:0] inv_mid,
    output logic [CNT_W-1:0] inv_lo
);

    typedef enum logic [1:0] {IDLE, SELECT, EJECT, FIN} state_t;

    localparam logic [WIDTH-1:0] HI_V  = WIDTH'(DEN_HI);
    localparam logic [WIDTH-1:0] MID_V = WIDTH'(DEN_MID);
    localparam logic [WIDTH-1:0] LO_V  = WIDTH'(DEN_LO);
    localparam logic [CNT_W-1:0] INV0  = CNT_W'(INIT_INV);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_LO   = 2'b01;
    localparam logic [1:0] SEL_MID  = 2'b10;
    localparam logic [1:0] SEL_HI   = 2'b11;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [1:0]       pick;
    logic [WIDTH-1:0] coin_val;

    // Greedy choice: a coin is eligible only if it fits in rem and is in stock.
    always_comb begin
        // NOTE: default first so every path assigns pick and no latch is inferred.
        pick = SEL_NONE;
        if (rem >= HI_V && inv_hi != '0)
            pick = SEL_HI;
        else if (rem >= MID_V && inv_mid != '0)
            pick = SEL_MID;
        else if (rem >= LO_V && inv_lo != '0)
            pick = SEL_LO;
    end

    always_comb begin
        coin_val = '0;
        case (coin_sel)
            SEL_HI:  coin_val = HI_V;
            SEL_MID: coin_val = MID_V;
            SEL_LO:  coin_val = LO_V;
            default: coin_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every branch sees pre-edge values.
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            coin_valid <= 1'b0;
            coin_sel   <= SEL_NONE;
            busy       <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
            remaining  <= '0;
            inv_hi     <= INV0;
            inv_mid    <= INV0;
            inv_lo     <= INV0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        inv_hi  <= load_hi;
                        inv_mid <= load_mid;
                        inv_lo  <= load_lo;
                    end
                    if (start) begin
                        rem       <= amount;
                        short     <= 1'b0;
                        remaining <= '0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (pick != SEL_NONE) begin
                        coin_sel   <= pick;
                        coin_valid <= 1'b1;
                        state      <= EJECT;
                    end else begin
                        // Nothing eligible: either fully paid or out of usable coins.
                        short     <= (rem != '0);
                        remaining <= rem;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                EJECT: begin
                    if (coin_ready) begin
                        rem <= rem - coin_val;
                        case (coin_sel)
                            SEL_HI:  inv_hi  <= inv_hi - 1'b1;
                            SEL_MID: inv_mid <= inv_mid - 1'b1;
                            SEL_LO:  inv_lo  <= inv_lo - 1'b1;
                            default: ;
                        endcase
                        coin_valid <= 1'b0;
                        coin_sel   <= SEL_NONE;
                        state      <= SELECT;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table-driven payouts plus hand-written corner
// sequences; expected coins are queued at start and popped on each ejector handshake.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst, start, load, coin_ready;
    logic [7:0] amount;
    logic [3:0] load_hi, load_mid, load_lo;
    logic       coin_valid, busy, done, short;
    logic [1:0] coin_sel;
    logic [7:0] remaining;
    logic [3:0] inv_hi, inv_mid, inv_lo;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        int         load_mode;   // 0 none, 1 load the cycle before start, 2 load with start
        logic [3:0] lhi, lmid, llo;
        logic [7:0] amt;
        logic [23:0] seq;        // expected coin codes, first coin in the most significant used pair
        int         n;
        logic       e_short;
        logic [7:0] e_rem;
        logic [3:0] e_hi, e_mid, e_lo;
    } vec_t;

    vec_t tbl[7];

    change_dispenser dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount), .load(load),
        .load_hi(load_hi), .load_mid(load_mid), .load_lo(load_lo),
        .coin_valid(coin_valid), .coin_sel(coin_sel), .coin_ready(coin_ready),
        .busy(busy), .done(done), .short(short), .remaining(remaining),
        .inv_hi(inv_hi), .inv_mid(inv_mid), .inv_lo(inv_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every accepted coin must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && coin_valid && coin_ready) begin
            if (exp_q.size() == 0)
                check("coin_unexpected", {30'd0, coin_sel}, 32'd0 - 1);
            else
                check("coin_sel", {30'd0, coin_sel}, {30'd0, exp_q.pop_front()});
        end
    end

    task automatic wait_done(output int n, output logic got);
        n   = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic run_row(input vec_t r, input string tag);
        int   n;
        logic got;
        if (r.load_mode == 1) begin
            load = 1'b1; load_hi = r.lhi; load_mid = r.lmid; load_lo = r.llo;
            tick();
            load = 1'b0;
        end
        for (int i = 0; i < r.n; i++) exp_q.push_back(r.seq[2*(r.n-1-i) +: 2]);
        if (r.load_mode == 2) begin
            load = 1'b1; load_hi = r.lhi; load_mid = r.lmid; load_lo = r.llo;
        end
        start = 1'b1; amount = r.amt; coin_ready = 1'b1;
        tick();
        start = 1'b0; load = 1'b0;
        n = 0; got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, "_short_cleared"}, {31'd0, short}, 0);
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, got}, 1);
        check({tag, "_latency"}, n, 2 * r.n + 2);
        check({tag, "_short"}, {31'd0, short}, {31'd0, r.e_short});
        check({tag, "_remaining"}, {24'd0, remaining}, {24'd0, r.e_rem});
        check({tag, "_inv_hi"}, {28'd0, inv_hi}, {28'd0, r.e_hi});
        check({tag, "_inv_mid"}, {28'd0, inv_mid}, {28'd0, r.e_mid});
        check({tag, "_inv_lo"}, {28'd0, inv_lo}, {28'd0, r.e_lo});
        check({tag, "_coins_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 0);
        check({tag, "_hold"}, {23'd0, short, remaining}, {23'd0, r.e_short, r.e_rem});
    endtask

    initial begin
        int   n;
        logic got;
        logic held;
        vec_t r;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic got;
        logic extra;
        vec_t r;

        tbl[0] = '{0, 4'd0, 4'd0, 4'd0, 8'd27,  24'({2'd3,2'd3,2'd2,2'd1,2'd1}), 5, 1'b0, 8'd0,   4'd2,  4'd3,  4'd2};
        tbl[1] = '{1, 4'd1, 4'd0, 4'd2, 8'd17,  24'({2'd3,2'd1,2'd1}),           3, 1'b1, 8'd5,   4'd0,  4'd0,  4'd0};
        tbl[2] = '{1, 4'd4, 4'd4, 4'd4, 8'd0,   24'd0,                           0, 1'b0, 8'd0,   4'd4,  4'd4,  4'd4};
        tbl[3] = '{0, 4'd0, 4'd0, 4'd0, 8'd16,  24'({2'd3,2'd2,2'd1}),           3, 1'b0, 8'd0,   4'd3,  4'd3,  4'd3};
        tbl[4] = '{0, 4'd0, 4'd0, 4'd0, 8'd255,
                   24'({2'd3,2'd3,2'd3,2'd2,2'd2,2'd2,2'd1,2'd1,2'd1}),          9, 1'b1, 8'd207, 4'd0,  4'd0,  4'd0};
        tbl[5] = '{2, 4'd0, 4'd4, 4'd4, 8'd10,  24'({2'd2,2'd2}),                2, 1'b0, 8'd0,   4'd0,  4'd2,  4'd4};
        tbl[6] = '{1, 4'd15, 4'd15, 4'd15, 8'd4, 24'({2'd1,2'd1,2'd1,2'd1}),     4, 1'b0, 8'd0,   4'd15, 4'd15, 4'd11};

        rst = 1'b1; start = 1'b0; load = 1'b0; coin_ready = 1'b0;
        amount = '0; load_hi = '0; load_mid = '0; load_lo = '0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {27'd0, coin_valid, coin_sel, busy, done, short}, 0);
        check("reset_remaining", {24'd0, remaining}, 0);
        check("reset_inv", {20'd0, inv_hi, inv_mid, inv_lo}, {20'd0, 12'h444});

        for (int i = 0; i < 7; i++) run_row(tbl[i], $sformatf("row%0d", i));

        // Ejector stalls for three cycles: request and selection must hold, inventory untouched.
        tick();
        coin_ready = 1'b0;
        exp_q.push_back(2'd3);
        start = 1'b1; amount = 8'd10;
        tick();
        start = 1'b0;
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (coin_valid) got = 1'b1;
        end
        check("stall_valid_seen", {31'd0, got}, 1);
        check("stall_valid_latency", n, 2);
        for (int k = 0; k < 3; k++) begin
            check("stall_hold", {25'd0, coin_valid, coin_sel, inv_hi}, {25'd0, 1'b1, 2'd3, 4'd15});
            if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 coin_ready = 1'b1;
        wait_done(n, got);
        check("stall_done_seen", {31'd0, got}, 1);
        check("stall_inv_hi", {28'd0, inv_hi}, 14);
        check("stall_short", {31'd0, short}, 0);

        // start and load pulsed mid-payout must be ignored entirely.
        tick(); tick();
        r = '{0, 4'd0, 4'd0, 4'd0, 8'd27, 24'({2'd3,2'd3,2'd2,2'd1,2'd1}), 5, 1'b0, 8'd0, 4'd12, 4'd14, 4'd9};
        for (int i = 0; i < r.n; i++) exp_q.push_back(r.seq[2*(r.n-1-i) +: 2]);
        start = 1'b1; amount = 8'd27;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; amount = 8'd99;
        load = 1'b1; load_hi = 4'd0; load_mid = 4'd0; load_lo = 4'd0;
        tick();
        start = 1'b0; load = 1'b0;
        wait_done(n, got);
        check("busy_done_seen", {31'd0, got}, 1);
        check("busy_inv", {20'd0, inv_hi, inv_mid, inv_lo}, {20'd0, r.e_hi, r.e_mid, r.e_lo});
        check("busy_coins_left", exp_q.size(), 0);
        extra = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k > 0) extra = extra | busy | done | coin_valid;
        end
        check("busy_no_requeue", {31'd0, extra}, 0);

        // Reset while a coin is pending in EJECT.
        tick();
        coin_ready = 1'b0;
        exp_q.push_back(2'd3);
        start = 1'b1; amount = 8'd27;
        tick();
        start = 1'b0;
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (coin_valid) got = 1'b1;
        end
        check("rst_eject_reached", {31'd0, got}, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_ctrl", {29'd0, coin_valid, busy, done}, 0);
        check("rst_mid_inv", {20'd0, inv_hi, inv_mid, inv_lo}, {20'd0, 12'h444});
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        coin_ready = 1'b1;
        r = '{0, 4'd0, 4'd0, 4'd0, 8'd6, 24'({2'd2,2'd1}), 2, 1'b0, 8'd0, 4'd4, 4'd3, 4'd3};
        run_row(r, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
